param_ram_clr: RTL and testbench
================================

Name: param_ram_clr

Overview:
- Parametrised successor to the fixed 64x20 register RAM.
- Single write port and independent registered read port.
- Built-in sequential clear engine that sweeps every word to CLEAR_VAL after reset or on request.
- Used as wavetable/parameter storage in the synth datapath; read port feeds the oscillator pipeline at one word per clock.

Parameters:
WIDTH, 20, data word width in bits
DEPTH, 64, number of words; any integer >= 2
ADDR_W, 6, address width; must satisfy 2**ADDR_W >= DEPTH
CLEAR_VAL, 0, WIDTH-bit value written to every word by the clear engine
INIT_CLEAR, 1, 1 = clear sweep starts automatically after reset release; 0 = only on clear request

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
load  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data
clear  input  1  single-cycle request to start a clear sweep
busy  output  1  high while clear sweep in progress
wr_drop  output  1  one-cycle pulse: a user write was discarded

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rd_data=0, busy=0, wr_drop=0, sweep counter=0, FSM=IDLE.
  - Array contents are not reset.
- FSM states:
  - IDLE:
    - On the first clk edge after rst_n release, go to CLEAR if INIT_CLEAR=1.
    - Otherwise go to CLEAR when clear=1.
  - CLEAR:
    - Each cycle, write CLEAR_VAL to mem[cnt], then cnt++.
    - When cnt=DEPTH-1 is written, return to IDLE and reset cnt to 0.
    - Sweep takes exactly DEPTH cycles.
    - busy is a registered output, high exactly while in CLEAR.
- clear while already in CLEAR: ignored; the sweep is not restarted.
- rst_n asserted mid-sweep: the sweep aborts immediately. After release it restarts from address 0 when INIT_CLEAR=1. Words not yet cleared are left undefined.
- User write:
  - On a clk edge with load=1 and busy=0, mem[wr_addr] <= wr_data.
  - load=1 while busy=1: the write is discarded and wr_drop=1 on the following cycle. No queueing.
  - wr_addr >= DEPTH (non-power-of-2 DEPTH): write ignored, no wr_drop.
- Read:
  - rd_data <= mem[rd_addr] on every clk edge; one-cycle latency; reads are allowed during the sweep.
  - rd_addr >= DEPTH returns CLEAR_VAL.
- Read/write collision (same address, same edge): write-first; rd_data returns the new wr_data.
  - The same rule applies to the clear engine's write: reading cnt in the cycle it is cleared returns CLEAR_VAL.
- No wrap hazards: cnt is ADDR_W bits and its terminal compare is against DEPTH-1, not 2**ADDR_W-1.

Test Plan:
1. Reset with INIT_CLEAR=1, DEPTH=64:
   - busy rises on the first edge after rst_n=1 and stays high for 64 cycles, then falls.
   - Reading addresses 0..63 afterwards returns 0.
2. After the sweep, load=1 with wr_addr=i, wr_data=i for i=0..63; then read rd_addr=i:
   - rd_data=i one cycle after each address is presented.
   - Repeating the loop with load=0 and wr_data=i+2 leaves the contents unchanged.
3. Write 15 to addr 3 while rd_addr=3 on the same edge:
   - rd_data=15 on the next cycle (write-first).
   - A read of addr 0 in that cycle is unaffected.
4. Pulse clear; during the sweep drive load=1 with wr_addr=5, wr_data=7:
   - wr_drop pulses once.
   - After the sweep, mem[5]=0.
   - A second clear pulse mid-sweep does not extend busy beyond 64 cycles.
5. Assert rst_n=0 at sweep cycle 20:
   - busy and rd_data go to 0 immediately, without waiting for clk.
   - After release, the sweep restarts at address 0 and busy lasts 64 cycles.
6. Instance with DEPTH=48, ADDR_W=6, CLEAR_VAL=20'hABCDE:
   - Sweep lasts 48 cycles.
   - A write to addr 50 is ignored.
   - A read of addr 50 returns 20'hABCDE.

Source files
------------

// File: rtl/param_ram_clr.sv
// Parametrised single-write / registered-read RAM with a sequential clear engine
// that sweeps every word to CLEAR_VAL after reset release or on request.
module param_ram_clr #(
  parameter int               WIDTH      = 20,
  parameter int               DEPTH      = 64,
  parameter int               ADDR_W     = 6,
  parameter logic [WIDTH-1:0] CLEAR_VAL  = '0,
  parameter bit               INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              clear,
  output logic              busy,
  output logic              wr_drop
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt_next;
  logic              r_init_pend;
  logic              r_busy;
  logic              r_wr_drop;
  logic [WIDTH-1:0]  r_rd_data;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_wr_in_range, w_rd_in_range;
  logic              w_user_we, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;

  // r_init_pend marks the first edge after reset release so INIT_CLEAR can launch a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_init_pend <= INIT_CLEAR;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_init_pend <= 1'b0;
      r_busy      <= (w_state_next == S_CLEAR);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (r_init_pend || clear) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_cnt == LAST) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The clear engine owns the single write port while sweeping
  assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  assign w_user_we     = load && !r_busy && w_wr_in_range;
  assign w_we          = r_busy || w_user_we;
  assign w_waddr       = r_busy ? r_cnt : wr_addr;
  assign w_wdata       = r_busy ? CLEAR_VAL : wr_data;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Write-first: a same-edge write to the read address is forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= load && r_busy && w_wr_in_range;
      if (!w_rd_in_range)
        r_rd_data <= CLEAR_VAL;
      else if (w_we && (w_waddr == rd_addr))
        r_rd_data <= w_wdata;
      else
        r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_param_ram_clr.sv
// Self-checking bench for param_ram_clr: a default 64-word instance and a 48-word
// instance, checked against an array model of the memory contents.
module tb_param_ram_clr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_n, load, clear;
  logic [5:0]  wr_addr, rd_addr;
  logic [19:0] wr_data, rd_data;
  logic        busy, wr_drop;

  // Instance B: DEPTH=48, CLEAR_VAL=20'hABCDE
  logic        rst_n_b, load_b, clear_b;
  logic [5:0]  wr_addr_b, rd_addr_b;
  logic [19:0] wr_data_b, rd_data_b;
  logic        busy_b, wr_drop_b;

  param_ram_clr dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .clear(clear), .busy(busy), .wr_drop(wr_drop)
  );

  param_ram_clr #(
    .WIDTH(20), .DEPTH(48), .ADDR_W(6), .CLEAR_VAL(20'hABCDE), .INIT_CLEAR(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .load(load_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .clear(clear_b), .busy(busy_b), .wr_drop(wr_drop_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] model_a [64];

  task automatic step;
    @(negedge clk);
  endtask

  task automatic model_clear_a;
    for (int i = 0; i < 64; i++) model_a[i] = 20'h0;
  endtask

  task automatic test_reset;
    int n;
    step; step;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    rst_n = 1'b1;
    step;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL init_busy_rise got=%b exp=1", busy); end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step;
      if (!busy) break;
      n++;
    end
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL init_sweep_len got=%0d exp=64", n); end
    $display("reset: init sweep lasted %0d cycles", n);
    model_clear_a();
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      step;
      n_checks++;
      if (rd_data !== model_a[i]) begin n_fail++; $display("FAIL init_read addr=%0d got=%h exp=%h", i, rd_data, model_a[i]); end
    end
  endtask

  task automatic test_write_read;
    for (int i = 0; i < 64; i++) begin
      load = 1'b1; wr_addr = 6'(i); wr_data = 20'(i);
      step;
      model_a[i] = 20'(i);
    end
    load = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      step;
      n_checks++;
      if (rd_data !== model_a[i]) begin n_fail++; $display("FAIL wr_read addr=%0d got=%h exp=%h", i, rd_data, model_a[i]); end
    end
    for (int i = 0; i < 64; i++) begin
      load = 1'b0; wr_addr = 6'(i); wr_data = 20'(i + 2); rd_addr = 6'(i);
      step;
      n_checks++;
      if (rd_data !== model_a[i]) begin n_fail++; $display("FAIL noload_read addr=%0d got=%h exp=%h", i, rd_data, model_a[i]); end
    end
    $display("write_read: 64 words written and read back twice");
  endtask

  task automatic test_collision;
    logic [19:0] d;
    load = 1'b1; wr_addr = 6'd3; wr_data = 20'd15; rd_addr = 6'd3;
    step;
    load = 1'b0;
    model_a[3] = 20'd15;
    n_checks++; if (rd_data !== 20'd15) begin n_fail++; $display("FAIL collide_same got=%h exp=%h", rd_data, 20'd15); end
    d = 20'($urandom);
    load = 1'b1; wr_addr = 6'd3; wr_data = d; rd_addr = 6'd0;
    step;
    load = 1'b0;
    n_checks++; if (rd_data !== model_a[0]) begin n_fail++; $display("FAIL collide_other got=%h exp=%h", rd_data, model_a[0]); end
    model_a[3] = d;
    rd_addr = 6'd3;
    step;
    n_checks++; if (rd_data !== model_a[3]) begin n_fail++; $display("FAIL collide_after got=%h exp=%h", rd_data, model_a[3]); end
    $display("collision: write-first on addr 3, addr 0 unaffected");
  endtask

  task automatic test_clear_drop;
    int n, drops, a;
    clear = 1'b1;
    step;
    clear = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise got=%b exp=1", busy); end
    n = 1; drops = 0;
    for (int i = 0; i < 200; i++) begin
      load = (n == 3); wr_addr = 6'd5; wr_data = 20'd7;
      clear = (n == 30);
      rd_addr = 6'(n - 1);
      step;
      drops += int'(wr_drop);
      n_checks++;
      if (rd_data !== 20'h0) begin n_fail++; $display("FAIL sweep_read addr=%0d got=%h exp=0", n - 1, rd_data); end
      if (!busy) break;
      n++;
    end
    load = 1'b0; clear = 1'b0;
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL clr_sweep_len got=%0d exp=64", n); end
    n_checks++; if (drops != 1) begin n_fail++; $display("FAIL wr_drop_count got=%0d exp=1", drops); end
    model_clear_a();
    rd_addr = 6'd5;
    step;
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL dropped_write got=%h exp=0", rd_data); end
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 63);
      rd_addr = 6'(a);
      step;
      n_checks++;
      if (rd_data !== model_a[a]) begin n_fail++; $display("FAIL post_clr_read addr=%0d got=%h exp=%h", a, rd_data, model_a[a]); end
    end
    $display("clear_drop: sweep %0d cycles, %0d drop pulses", n, drops);
  endtask

  task automatic test_random;
    logic [19:0] exp_rd;
    for (int i = 0; i < 150; i++) begin
      load    = 1'($urandom_range(0, 1));
      wr_addr = 6'($urandom_range(0, 63));
      wr_data = 20'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
      exp_rd  = (load && wr_addr == rd_addr) ? wr_data : model_a[rd_addr];
      if (load) model_a[wr_addr] = wr_data;
      step;
      n_checks++;
      if (rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", i, rd_addr, rd_data, exp_rd); end
    end
    load = 1'b0;
    $display("random: 150 mixed read/write cycles");
  endtask

  task automatic test_reset_mid;
    int n;
    load = 1'b1; wr_addr = 6'd63; wr_data = 20'hFFFFF;
    step;
    load = 1'b0;
    model_a[63] = 20'hFFFFF;
    rd_addr = 6'd63;
    clear = 1'b1;
    step;
    clear = 1'b0;
    n = 1;
    for (int i = 0; i < 19; i++) begin
      step;
      if (busy) n++;
    end
    n_checks++; if (n != 20) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=20", n); end
    n_checks++; if (rd_data !== model_a[63]) begin n_fail++; $display("FAIL mid_pre_read got=%h exp=%h", rd_data, model_a[63]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL async_rd_data got=%h exp=0", rd_data); end
    step;
    rst_n = 1'b1;
    step;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b exp=1", busy); end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step;
      if (!busy) break;
      n++;
    end
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL restart_len got=%0d exp=64", n); end
    model_clear_a();
    for (int i = 0; i < 64; i += 9) begin
      rd_addr = 6'(i);
      step;
      n_checks++;
      if (rd_data !== model_a[i]) begin n_fail++; $display("FAIL restart_read addr=%0d got=%h exp=%h", i, rd_data, model_a[i]); end
    end
    rd_addr = 6'd63;
    step;
    n_checks++; if (rd_data !== 20'h0) begin n_fail++; $display("FAIL restart_read63 got=%h exp=0", rd_data); end
    $display("reset_mid: async abort, restart sweep %0d cycles", n);
  endtask

  task automatic test_depth48;
    int n;
    logic [19:0] d;
    rst_n_b = 1'b1;
    step;
    n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL b_busy_rise got=%b exp=1", busy_b); end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      step;
      if (!busy_b) break;
      n++;
    end
    n_checks++; if (n != 48) begin n_fail++; $display("FAIL b_sweep_len got=%0d exp=48", n); end
    load_b = 1'b1; wr_addr_b = 6'd50; wr_data_b = 20'($urandom); rd_addr_b = 6'd50;
    step;
    load_b = 1'b0;
    n_checks++; if (rd_data_b !== 20'hABCDE) begin n_fail++; $display("FAIL b_read50 got=%h exp=abcde", rd_data_b); end
    rd_addr_b = 6'd2;
    step;
    n_checks++; if (wr_drop_b !== 1'b0) begin n_fail++; $display("FAIL b_wr_drop got=%b exp=0", wr_drop_b); end
    n_checks++; if (rd_data_b !== 20'hABCDE) begin n_fail++; $display("FAIL b_read2 got=%h exp=abcde", rd_data_b); end
    d = 20'($urandom);
    load_b = 1'b1; wr_addr_b = 6'd47; wr_data_b = d; rd_addr_b = 6'd0;
    step;
    load_b = 1'b0;
    n_checks++; if (rd_data_b !== 20'hABCDE) begin n_fail++; $display("FAIL b_read0 got=%h exp=abcde", rd_data_b); end
    rd_addr_b = 6'd47;
    step;
    n_checks++; if (rd_data_b !== d) begin n_fail++; $display("FAIL b_read47 got=%h exp=%h", rd_data_b, d); end
    $display("depth48: sweep %0d cycles, addr 50 ignored", n);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; clear = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rst_n_b = 1'b0; load_b = 1'b0; clear_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_clear_drop();
    test_random();
    test_reset_mid();
    test_depth48();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
